// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM port arbiter and its round-robin picker.
// Contents:
//   ID_W(n)     width of a binary requester id for n requesters (minimum 1)
//   owner_t     one stage of the in-flight owner pipe {valid, requester id}
//   MAX_*       upper limits on the supported parameter ranges
package sram_arb_pkg;

  localparam int MAX_NUM    = 8;
  localparam int MAX_RD_LAT = 4;
  localparam int MAX_WAIT   = 7;

  function automatic int ID_W(input int n);
    return $clog2(n > 1 ? n : 2);
  endfunction

  // The owner id is sized for the largest supported requester count so the
  // struct can live in the package independent of any instance's NUM.
  localparam int OWNER_ID_W = ID_W(MAX_NUM);

  typedef struct packed {
    logic                  v;
    logic [OWNER_ID_W-1:0] id;
  } owner_t;

endpackage

// File: rtl/sram_arb_rr_pick.sv
// Combinational round-robin picker.
// Scans req starting at ptr and wrapping modulo NUM; the first set bit wins.
// Ports:
//   req  in   NUM   request vector
//   ptr  in   IDW   index with highest priority this cycle (must be < NUM)
//   gnt  out  NUM   one-hot winner, zero when no request is set
//   id   out  IDW   binary index of the winner, 0 when no request is set
module sram_arb_rr_pick
  import sram_arb_pkg::*;
#(
  parameter int NUM = 2,
  parameter int IDW = ID_W(NUM)
) (
  input  logic [NUM-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [NUM-1:0] gnt,
  output logic [IDW-1:0] id
);

  function automatic int wrap_idx(input int base, input int k);
    int idx;
    idx = base + k;
    if (idx >= NUM) idx = idx - NUM;
    return idx;
  endfunction

  logic found;

  // Outer loop walks priority order, inner loop keeps every bit select
  // constant so the picker stays a flat mux tree.
  always_comb begin
    gnt   = '0;
    id    = '0;
    found = 1'b0;
    for (int k = 0; k < NUM; k++) begin
      for (int i = 0; i < NUM; i++) begin
        if (!found && req[i] && (i == wrap_idx(int'(ptr), k))) begin
          gnt[i] = 1'b1;
          id     = IDW'(i);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between NUM requesters with round-robin grants,
// optional wait states after every access, and an owner pipe that routes each
// response back to the requester that issued it RD_LAT cycles earlier.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req/wr                per-requester request and write flag
//   addr/wdata/be         per-requester byte address, write data, byte enables
//   gnt                   one-hot grant, combinational from req
//   rvalid/rdata          one-hot response strobe and shared response data
//   mem_en/mem_we         SRAM enable and write enable
//   mem_addr/mem_be       SRAM word address and byte enables (4'hf on reads)
//   mem_wdata/mem_rdata   SRAM write data (0 on reads) and read data
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM         = 2,
  parameter int DEPTH       = 16384,
  parameter int ADDR_WIDTH  = $clog2(DEPTH),
  parameter int RD_LAT      = 1,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM-1:0]        req,
  input  logic [NUM-1:0]        wr,
  input  logic [NUM*32-1:0]     addr,
  input  logic [NUM*32-1:0]     wdata,
  input  logic [NUM*4-1:0]      be,
  output logic [NUM-1:0]        gnt,
  output logic [NUM-1:0]        rvalid,
  output logic [31:0]           rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int IDW = ID_W(NUM);

  logic [IDW-1:0]              ptr;
  logic [IDW-1:0]              win_id;
  logic [IDW-1:0]              next_ptr;
  logic [NUM-1:0]              pick_gnt;
  logic [2:0]                  busy_cnt;
  owner_t [RD_LAT-1:0]         pipe;
  owner_t                      head;
  logic                        grant_ok;
  logic                        granted;
  logic                        unused_addr_bits;

  sram_arb_rr_pick #(
    .NUM (NUM),
    .IDW (IDW)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .id  (win_id)
  );

  assign grant_ok = !reset && (busy_cnt == 3'd0);
  assign gnt      = grant_ok ? pick_gnt : '0;
  assign granted  = |gnt;
  assign next_ptr = (win_id == IDW'(NUM - 1)) ? '0 : win_id + IDW'(1);

  // Only the word-address bits reach the SRAM.
  assign unused_addr_bits = ^addr;

  // gnt is one-hot, so an OR of the granted requester's fields is a clean mux.
  always_comb begin
    mem_en    = granted;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = 4'h0;
    mem_wdata = '0;
    for (int i = 0; i < NUM; i++) begin
      if (gnt[i]) begin
        mem_we   = wr[i];
        mem_addr = addr[32*i+2 +: ADDR_WIDTH];
        if (wr[i]) begin
          mem_be    = be[4*i +: 4];
          mem_wdata = wdata[32*i +: 32];
        end else begin
          mem_be    = 4'hf;
        end
      end
    end
  end

  // The last pipe stage lines up with mem_rdata of the access it describes.
  assign head = pipe[RD_LAT-1];

  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!reset && head.v) begin
      rdata = mem_rdata;
      for (int i = 0; i < NUM; i++) begin
        rvalid[i] = (head.id == OWNER_ID_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      busy_cnt <= 3'd0;
      pipe     <= '0;
    end else begin
      if (granted) begin
        ptr      <= next_ptr;
        busy_cnt <= 3'(WAIT_STATES);
      end else if (busy_cnt != 3'd0) begin
        busy_cnt <= busy_cnt - 3'd1;
      end
      pipe[0] <= {granted, OWNER_ID_W'(win_id)};
      for (int s = 1; s < RD_LAT; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  // Instance 0: NUM=2, RD_LAT=1, WAIT_STATES=0
  // Instance 1: NUM=4, RD_LAT=3, WAIT_STATES=2
  function automatic int nump(input int i); return (i == 0) ? 2 : 4; endfunction
  function automatic int rdl(input int i);  return (i == 0) ? 1 : 3; endfunction
  function automatic int wsn(input int i);  return (i == 0) ? 0 : 2; endfunction
  function automatic logic [31:0] pat(input int k); return 32'hA000_0000 + 32'(k); endfunction

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  rst_s;
  logic        preload;
  logic [3:0]  req_s   [2];
  logic [3:0]  wr_s    [2];
  logic [31:0] addr_s  [2][4];
  logic [31:0] wdata_s [2][4];
  logic [3:0]  be_s    [2][4];

  // ---------------- instance 0 ----------------
  logic [1:0]  a_req, a_wr, a_gnt, a_rvalid;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_be;
  logic [31:0] a_rdata, a_mwdata, a_mrdata;
  logic        a_men, a_mwe;
  logic [AW-1:0] a_maddr;
  logic [3:0]  a_mbe;

  always_comb begin
    a_req = req_s[0][1:0];
    a_wr  = wr_s[0][1:0];
    a_addr = '0; a_wdata = '0; a_be = '0;
    for (int k = 0; k < 2; k++) begin
      a_addr[32*k +: 32]  = addr_s[0][k];
      a_wdata[32*k +: 32] = wdata_s[0][k];
      a_be[4*k +: 4]      = be_s[0][k];
    end
  end

  sram_port_arbiter #(.NUM(2), .DEPTH(DEPTH), .RD_LAT(1), .WAIT_STATES(0)) dut_a (
    .clk(clk), .reset(rst_s[0]), .req(a_req), .wr(a_wr), .addr(a_addr),
    .wdata(a_wdata), .be(a_be), .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata),
    .mem_en(a_men), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_be(a_mbe),
    .mem_wdata(a_mwdata), .mem_rdata(a_mrdata)
  );

  // ---------------- instance 1 ----------------
  logic [3:0]   b_req, b_wr, b_gnt, b_rvalid;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_be;
  logic [31:0]  b_rdata, b_mwdata, b_mrdata;
  logic         b_men, b_mwe;
  logic [AW-1:0] b_maddr;
  logic [3:0]   b_mbe;

  always_comb begin
    b_req = req_s[1];
    b_wr  = wr_s[1];
    b_addr = '0; b_wdata = '0; b_be = '0;
    for (int k = 0; k < 4; k++) begin
      b_addr[32*k +: 32]  = addr_s[1][k];
      b_wdata[32*k +: 32] = wdata_s[1][k];
      b_be[4*k +: 4]      = be_s[1][k];
    end
  end

  sram_port_arbiter #(.NUM(4), .DEPTH(DEPTH), .RD_LAT(3), .WAIT_STATES(2)) dut_b (
    .clk(clk), .reset(rst_s[1]), .req(b_req), .wr(b_wr), .addr(b_addr),
    .wdata(b_wdata), .be(b_be), .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata),
    .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_be(b_mbe),
    .mem_wdata(b_mwdata), .mem_rdata(b_mrdata)
  );

  // ---------------- SRAM models (read-before-write, RD_LAT-deep output pipe) ----------------
  logic [31:0] mem [2][DEPTH];
  logic [31:0] rp  [2][4];

  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[0][k] <= pat(k);
        mem[1][k] <= pat(k);
      end
    end else begin
      rp[0][0] <= a_men ? mem[0][a_maddr] : 32'hDEAD_BEEF;
      rp[1][0] <= b_men ? mem[1][b_maddr] : 32'hDEAD_BEEF;
      for (int b = 0; b < 4; b++) begin
        if (a_men && a_mwe && a_mbe[b]) mem[0][a_maddr][8*b +: 8] <= a_mwdata[8*b +: 8];
        if (b_men && b_mwe && b_mbe[b]) mem[1][b_maddr][8*b +: 8] <= b_mwdata[8*b +: 8];
      end
      for (int s = 1; s < 4; s++) begin
        rp[0][s] <= rp[0][s-1];
        rp[1][s] <= rp[1][s-1];
      end
    end
  end

  assign a_mrdata = rp[0][0];
  assign b_mrdata = rp[1][2];

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%h want=%h", nm, inst, cyc, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [3:0] v);
    int r;
    r = -1;
    for (int k = 0; k < 4; k++) if (v[k]) r = (r < 0) ? k : 99;
    return r;
  endfunction

  // DUT observation logs (indexed by cycle) for the hand-computed checks
  int          glog  [2][256];
  int          rvlog [2][256];
  logic [31:0] rdlog [2][256];
  logic [31:0] malog [2][256];
  logic        mwlog [2][256];
  logic [3:0]  mblog [2][256];

  // Reference model state: priority pointer, cooldown, scheduled responses, shadow memory
  int          m_ptr [2];
  int          m_cnt [2];
  logic        sv    [2][64];
  int          sid   [2][64];
  logic [31:0] sd    [2][64];
  logic [31:0] shadow[2][DEPTH];

  task automatic model_cycle(input int i);
    int n, w, idx, slot, word;
    logic [3:0] g, rv, eg, erv;
    logic [31:0] rd, erd, mwd;
    logic men, mwe;
    logic [AW-1:0] ma;
    logic [3:0] mb;
    if (i == 0) begin
      g = {2'b0, a_gnt}; rv = {2'b0, a_rvalid}; rd = a_rdata;
      men = a_men; mwe = a_mwe; ma = a_maddr; mb = a_mbe; mwd = a_mwdata;
    end else begin
      g = b_gnt; rv = b_rvalid; rd = b_rdata;
      men = b_men; mwe = b_mwe; ma = b_maddr; mb = b_mbe; mwd = b_mwdata;
    end
    n = nump(i);
    w = -1;
    slot = cyc % 64;
    if (!rst_s[i] && m_cnt[i] == 0) begin
      for (int k = 0; k < n; k++) begin
        idx = (m_ptr[i] + k) % n;
        if (w < 0 && req_s[i][idx]) w = idx;
      end
    end
    eg = (w >= 0) ? 4'(1 << w) : 4'h0;
    chk("gnt", i, 32'(g), 32'(eg));
    chk("mem_en", i, 32'(men), (w >= 0) ? 32'd1 : 32'd0);
    word = 0;
    if (w >= 0) begin
      word = int'(addr_s[i][w][7:2]);
      chk("mem_we", i, 32'(mwe), 32'(wr_s[i][w]));
      chk("mem_addr", i, 32'(ma), 32'(word));
      chk("mem_be", i, 32'(mb), wr_s[i][w] ? 32'(be_s[i][w]) : 32'hF);
      chk("mem_wdata", i, mwd, wr_s[i][w] ? wdata_s[i][w] : 32'h0);
    end
    erv = (!rst_s[i] && sv[i][slot]) ? 4'(1 << sid[i][slot]) : 4'h0;
    erd = (!rst_s[i] && sv[i][slot]) ? sd[i][slot] : 32'h0;
    chk("rvalid", i, 32'(rv), 32'(erv));
    chk("rdata", i, rd, erd);

    glog[i][cyc % 256]  = oh2i(g);
    rvlog[i][cyc % 256] = oh2i(rv);
    rdlog[i][cyc % 256] = rd;
    malog[i][cyc % 256] = 32'(ma);
    mwlog[i][cyc % 256] = mwe;
    mblog[i][cyc % 256] = mb;

    if (rst_s[i]) begin
      m_ptr[i] = 0;
      m_cnt[i] = 0;
      for (int s = 0; s < 64; s++) sv[i][s] = 1'b0;
    end else begin
      sv[i][slot] = 1'b0;
      if (w >= 0) begin
        sv[i][(cyc + rdl(i)) % 64]  = 1'b1;
        sid[i][(cyc + rdl(i)) % 64] = w;
        sd[i][(cyc + rdl(i)) % 64]  = shadow[i][word];
        if (wr_s[i][w])
          for (int b = 0; b < 4; b++)
            if (be_s[i][w][b]) shadow[i][word][8*b +: 8] = wdata_s[i][w][8*b +: 8];
        m_ptr[i] = (w + 1) % n;
        m_cnt[i] = wsn(i);
      end else if (m_cnt[i] > 0) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = 0; m_cnt[i] = 0;
      for (int s = 0; s < 64; s++) begin sv[i][s] = 1'b0; sid[i][s] = 0; sd[i][s] = '0; end
      for (int k = 0; k < DEPTH; k++) shadow[i][k] = pat(k);
    end
    forever begin
      @(negedge clk);
      model_cycle(0);
      model_cycle(1);
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input int r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b);
    req_s[i][r] = 1'b1; wr_s[i][r] = w; addr_s[i][r] = a; wdata_s[i][r] = d; be_s[i][r] = b;
  endtask

  task automatic clr_all();
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 4'h0; wr_s[i] = 4'h0;
      for (int r = 0; r < 4; r++) begin addr_s[i][r] = '0; wdata_s[i][r] = '0; be_s[i][r] = '0; end
    end
  endtask

  int b1, b2, b3, b4, b5, b6, bad_ids;

  initial begin
    clr_all();
    rst_s   = 2'b11;
    preload = 1'b1;
    // A request during reset must not be granted.
    set_rq(0, 0, 1'b0, 32'h40, 32'h0, 4'h0);
    step(); step();
    preload = 1'b0;
    step();
    for (int k = 0; k < 3; k++) chk("reset_no_gnt", 0, 32'(glog[0][k]), 32'hFFFF_FFFF);

    // Single ibus read at 0x40 -> word 0x10, response one cycle later.
    rst_s = 2'b00;
    clr_all();
    set_rq(0, 0, 1'b0, 32'h40, 32'h0, 4'h0);
    b1 = cyc;
    step();
    clr_all();
    repeat (3) step();
    chk("t1_gnt", 0, 32'(glog[0][b1]), 32'd0);
    chk("t1_maddr", 0, malog[0][b1], 32'h10);
    chk("t1_no_early_rv", 0, 32'(rvlog[0][b1]), 32'hFFFF_FFFF);
    chk("t1_rv", 0, 32'(rvlog[0][b1+1]), 32'd0);
    chk("t1_rdata", 0, rdlog[0][b1+1], 32'hA000_0010);

    // ibus and dbus both held from reset: strict alternation.
    rst_s[0] = 1'b1;
    step();
    rst_s[0] = 1'b0;
    set_rq(0, 0, 1'b0, 32'h20, 32'h0, 4'h0);
    set_rq(0, 1, 1'b0, 32'h24, 32'h0, 4'h0);
    b2 = cyc;
    repeat (6) step();
    clr_all();
    repeat (3) step();
    for (int k = 0; k < 6; k++) begin
      chk("t2_gnt", 0, 32'(glog[0][b2+k]), 32'(k % 2));
      chk("t2_rv", 0, 32'(rvlog[0][b2+k+1]), 32'(k % 2));
    end
    chk("t2_rdata0", 0, rdlog[0][b2+1], 32'hA000_0008);
    chk("t2_rdata1", 0, rdlog[0][b2+2], 32'hA000_0009);

    // dbus partial write then read back of 0x8 (word 2).
    set_rq(0, 1, 1'b1, 32'h8, 32'hA5A5_1234, 4'b0011);
    b3 = cyc;
    step();
    clr_all();
    set_rq(0, 1, 1'b0, 32'h8, 32'h0, 4'b0000);
    step();
    clr_all();
    repeat (3) step();
    chk("t3_we", 0, 32'(mwlog[0][b3]), 32'd1);
    chk("t3_be", 0, 32'(mblog[0][b3]), 32'h3);
    chk("t3_ack", 0, 32'(rvlog[0][b3+1]), 32'd1);
    chk("t3_rd_be", 0, 32'(mblog[0][b3+1]), 32'hF);
    chk("t3_rv", 0, 32'(rvlog[0][b3+2]), 32'd1);
    chk("t3_rdata", 0, rdlog[0][b3+2], 32'hA000_1234);

    // Instance 1: two continuous requesters with two wait states.
    rst_s[1] = 1'b1;
    step();
    rst_s[1] = 1'b0;
    set_rq(1, 0, 1'b0, 32'h30, 32'h0, 4'h0);
    set_rq(1, 1, 1'b0, 32'h34, 32'h0, 4'h0);
    b4 = cyc;
    repeat (10) step();
    clr_all();
    repeat (4) step();
    for (int k = 0; k < 10; k++)
      chk("t4_gnt", 1, 32'(glog[1][b4+k]), (k % 3 == 0) ? 32'((k / 3) % 2) : 32'hFFFF_FFFF);
    chk("t4_rv0", 1, 32'(rvlog[1][b4+3]), 32'd0);
    chk("t4_rv1", 1, 32'(rvlog[1][b4+6]), 32'd1);
    chk("t4_rd1", 1, rdlog[1][b4+6], 32'hA000_000D);

    // One-cycle reset right after two grants discards the second in flight.
    rst_s[1] = 1'b1;
    step();
    rst_s[1] = 1'b0;
    set_rq(1, 0, 1'b0, 32'h30, 32'h0, 4'h0);
    set_rq(1, 1, 1'b0, 32'h34, 32'h0, 4'h0);
    b5 = cyc;
    repeat (4) step();
    clr_all();
    rst_s[1] = 1'b1;
    step();
    rst_s[1] = 1'b0;
    repeat (4) step();
    set_rq(1, 0, 1'b0, 32'h30, 32'h0, 4'h0);
    set_rq(1, 3, 1'b0, 32'h3C, 32'h0, 4'h0);
    step();
    clr_all();
    repeat (4) step();
    chk("t5_gnt0", 1, 32'(glog[1][b5]), 32'd0);
    chk("t5_gnt1", 1, 32'(glog[1][b5+3]), 32'd1);
    chk("t5_rv_before", 1, 32'(rvlog[1][b5+3]), 32'd0);
    for (int k = 4; k < 9; k++) chk("t5_no_rv", 1, 32'(rvlog[1][b5+k]), 32'hFFFF_FFFF);
    chk("t5_next_gnt", 1, 32'(glog[1][b5+9]), 32'd0);

    // Pointer wrap: req[3] alone, then req[1] alone.
    rst_s[1] = 1'b1;
    step();
    rst_s[1] = 1'b0;
    set_rq(1, 3, 1'b0, 32'h3C, 32'h0, 4'h0);
    b6 = cyc;
    step();
    clr_all();
    step(); step();
    set_rq(1, 1, 1'b0, 32'h14, 32'h0, 4'h0);
    step();
    clr_all();
    repeat (5) step();
    chk("t6_gnt3", 1, 32'(glog[1][b6]), 32'd3);
    chk("t6_gnt1", 1, 32'(glog[1][b6+3]), 32'd1);
    chk("t6_rv3", 1, 32'(rvlog[1][b6+3]), 32'd3);
    chk("t6_rd3", 1, rdlog[1][b6+3], 32'hA000_000F);
    chk("t6_rv1", 1, 32'(rvlog[1][b6+6]), 32'd1);
    bad_ids = 0;
    for (int k = 0; k < 8; k++)
      if (rvlog[1][b6+k] == 0 || rvlog[1][b6+k] == 2) bad_ids++;
    chk("t6_no_rv_0_2", 1, 32'(bad_ids), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
